// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
//   sched_state_t : frame FSM states
//   HDR_TAG       : upper nibble of every frame header byte
//   MAX_BYTES     : longest frame (header + 4 sample bytes + checksum)
//   IDX_W         : width of the in-frame byte index
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        ACK    = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    localparam logic [3:0]  HDR_TAG   = 4'hA;
    localparam int unsigned MAX_BYTES = 6;
    localparam int unsigned IDX_W     = 3;

    // Pointer width for an n-entry round robin; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr and wrapping modulo N; first hit wins.
// Ports:
//   req       in  N   request vector
//   ptr       in  PW  highest-priority position
//   grant     out N   one-hot grant (zero when no request)
//   grant_idx out PW  index of the granted request
//   any       out 1   at least one request present
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [PW-1:0] cand;

    // Walk priority order ptr, ptr+1, ... and keep the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = PW'((32'(ptr) + off) % N);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter among N_CH sample channels.
// A round-robin grant captures one DATA_W sample, which is sent as a frame:
// header {HDR_TAG, ch}, then the sample bytes MSB first.
// Build option: define UART_SCHED_CHKSUM_EN to append an XOR checksum byte.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_valid   in  N_CH         channel has a sample pending
//   req_data    in  N_CH*DATA_W  channel i sample at [i*DATA_W +: DATA_W]
//   req_ready   out N_CH         one-hot accept pulse (combinational)
//   tx_data     out 8            byte for the UART
//   tx_valid    out 1            one-cycle launch strobe
//   tx_ready    in  1            UART idle
//   busy        out 1            frame in progress
//   frame_done  out 1            pulse when the last byte has completed
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned PW    = ptr_width(N_CH);
`ifdef UART_SCHED_CHKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES + 1);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES);
`endif

    sched_state_t      state, state_nxt;
    logic [PW-1:0]     rr_ptr;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] sel_sample;
    logic [3:0]        ch;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        cur_byte;
    logic              load;
    logic              advance;
    logic [N_CH-1:0]   arb_grant;
    logic [PW-1:0]     arb_idx;
    logic              arb_any;
`ifdef UART_SCHED_CHKSUM_EN
    logic [7:0]        chk;
`endif

    rr_arbiter #(
        .N  (N_CH),
        .PW (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Sample of the channel the arbiter is currently granting.
    always_comb begin
        sel_sample = req_data[DATA_W-1:0];
        for (int unsigned i = 1; i < N_CH; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_sample = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Byte mux: idx 0 is the header, 1..BYTES the sample MSB first.
    always_comb begin
        cur_byte = {HDR_TAG, ch};
        for (int unsigned k = 1; k <= BYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_byte = sample[DATA_W-8*k +: 8];
            end
        end
`ifdef UART_SCHED_CHKSUM_EN
        if (idx == LAST_IDX) begin
            cur_byte = chk;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        frame_done = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    load      = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (tx_ready) begin
                    tx_valid  = 1'b1;
                    tx_data   = cur_byte;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                // Falling ready means the UART has taken the byte.
                if (!tx_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = LAUNCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Frame context: captured sample, channel, byte index and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            sample <= '0;
            ch     <= '0;
            idx    <= '0;
        end else if (load) begin
            sample <= sel_sample;
            ch     <= 4'(arb_idx);
            idx    <= '0;
            rr_ptr <= (arb_idx == PW'(N_CH - 1)) ? '0 : arb_idx + PW'(1);
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
        end
    end

`ifdef UART_SCHED_CHKSUM_EN
    // Running XOR of every byte launched in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk <= 8'h00;
        end else if (load) begin
            chk <= 8'h00;
        end else if (tx_valid) begin
            chk <= chk ^ tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (N_CH=4, DATA_W=16).
module tb_uart_tx_scheduler;

    localparam int N_CH     = 4;
    localparam int DATA_W   = 16;
    localparam int BUSY_CYC = 20;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_ready;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    logic                   frame_done;

    int n_checks   = 0;
    int n_pass     = 0;
    int done_cnt   = 0;
    int strobe_cnt = 0;
    int ucnt       = 0;
    logic hold_low    = 1'b0;
    logic strobe_seen = 1'b0;

    logic [7:0]      exp_bytes[$];
    logic [N_CH-1:0] exp_grant[$];

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [3:0]  rdy;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t tbl[4];

    uart_tx_scheduler #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic push_frame(input int c, input logic [15:0] d);
        logic [7:0] h;
        h = {4'hA, 4'(c)};
        exp_bytes.push_back(h);
        exp_bytes.push_back(d[15:8]);
        exp_bytes.push_back(d[7:0]);
`ifdef UART_SCHED_CHKSUM_EN
        exp_bytes.push_back(h ^ d[15:8] ^ d[7:0]);
`endif
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        if (!seen) fail(name);
    endtask

    // UART model: ready drops after a strobe and returns after BUSY_CYC cycles.
    always begin
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) ucnt = 0;
        else if (strobe_seen) ucnt = BUSY_CYC;
        else if (ucnt > 0) ucnt--;
        tx_ready = (rst_n === 1'b1) && (ucnt == 0) && !hold_low;
    end

    // Monitor: scoreboard pops on every strobe and every grant.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tx_valid) begin
                strobe_cnt++;
                check("tx_ready_at_strobe", 32'(tx_ready), 32'd1);
                if (exp_bytes.size() == 0) fail("tx_unexpected_byte");
                else check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
            end
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) fail("req_ready_unexpected");
                else check("req_ready_grant", 32'(req_ready), 32'(exp_grant.pop_front()));
            end
            if (frame_done) done_cnt++;
            strobe_seen = tx_valid;
        end else begin
            strobe_seen = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int sc;
        bit seen;

        tbl[0] = '{2, 16'hBEEF, 4'b0100, 8'hA2, 8'hBE, 8'hEF, 8'hF3};
        tbl[1] = '{1, 16'h1234, 4'b0010, 8'hA1, 8'h12, 8'h34, 8'h87};
        tbl[2] = '{3, 16'h00FF, 4'b1000, 8'hA3, 8'h00, 8'hFF, 8'h5C};
        tbl[3] = '{0, 16'hA55A, 4'b0001, 8'hA0, 8'hA5, 8'h5A, 8'h5F};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        #3;
        check("rst_tx_valid",   32'(tx_valid),   32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // All channels held: strict rotation 0,1,2,3 then wrap to 0.
        req_data  = {16'h8883, 16'h4442, 16'h2221, 16'h0110};
        req_valid = 4'hF;
        d0 = done_cnt;
        exp_grant.push_back(4'b0001); push_frame(0, 16'h0110);
        exp_grant.push_back(4'b0010); push_frame(1, 16'h2221);
        exp_grant.push_back(4'b0100); push_frame(2, 16'h4442);
        exp_grant.push_back(4'b1000); push_frame(3, 16'h8883);
        exp_grant.push_back(4'b0001); push_frame(0, 16'h0110);
        for (int f = 0; f < 5; f++) wait_done("rot_frame_done");
        req_valid = '0;
        @(posedge clk); #2;
        check("rot_done_count", 32'(done_cnt - d0), 32'd5);
        check("rot_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("rot_grants_left", 32'(exp_grant.size()), 32'd0);

        // Single-channel frames from the table; req_valid drops right after grant.
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #2;
            req_data = '0;
            req_data[tbl[t].ch*16 +: 16] = tbl[t].data;
            req_valid = '0;
            req_valid[2'(tbl[t].ch)] = 1'b1;
            exp_grant.push_back(tbl[t].rdy);
            exp_bytes.push_back(tbl[t].b0);
            exp_bytes.push_back(tbl[t].b1);
            exp_bytes.push_back(tbl[t].b2);
`ifdef UART_SCHED_CHKSUM_EN
            exp_bytes.push_back(tbl[t].b3);
`endif
            d0 = done_cnt;
            #1 check("tbl_req_ready", 32'(req_ready), 32'(tbl[t].rdy));
            @(posedge clk); #2;
            req_valid = '0;
            req_data  = '0;
            @(negedge clk);
            check("tbl_first_byte_latency", 32'(tx_valid), 32'd1);
            wait_done("tbl_frame_done");
            @(posedge clk); #2;
            check("tbl_done_count", 32'(done_cnt - d0), 32'd1);
            check("tbl_bytes_left", 32'(exp_bytes.size()), 32'd0);
        end

        // UART held not-ready in LAUNCH: no strobe until ready returns.
        hold_low = 1'b1;
        @(posedge clk); #2;
        req_data = '0;
        req_data[15:0] = 16'h0F0F;
        req_valid = 4'b0001;
        exp_grant.push_back(4'b0001);
        push_frame(0, 16'h0F0F);
        @(posedge clk); #2;
        req_valid = '0;
        sc = strobe_cnt;
        repeat (50) @(posedge clk);
        #2;
        check("hold_no_tx_valid", 32'(strobe_cnt - sc), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        hold_low = 1'b0;
        @(posedge clk); #2;
        check("hold_ready_back", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check("hold_release_strobe", 32'(tx_valid), 32'd1);
        wait_done("hold_frame_done");
        @(posedge clk); #2;
        check("hold_bytes_left", 32'(exp_bytes.size()), 32'd0);

        // Reset during byte 2 of a ch2 frame; afterwards ch0 must win first.
        req_data = '0;
        req_data[47:32] = 16'hC3C3;
        req_valid = 4'b0100;
        exp_grant.push_back(4'b0100);
        push_frame(2, 16'hC3C3);
        sc = strobe_cnt;
        @(posedge clk); #2;
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (strobe_cnt - sc) >= 2;
        end
        if (!seen) fail("rst_wait_byte2");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_valid",   32'(tx_valid),   32'd0);
        check("midrst_tx_data",    32'(tx_data),    32'd0);
        check("midrst_busy",       32'(busy),       32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_req_ready",  32'(req_ready),  32'd0);
        exp_bytes.delete();
        exp_grant.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_valid = 4'hF;
        exp_grant.push_back(4'b0001);
        push_frame(0, 16'h1111);
        #1 check("postrst_grant_ch0", 32'(req_ready), 32'b0001);
        @(posedge clk); #2;
        req_valid = '0;
        wait_done("postrst_frame_done");
        @(posedge clk); #2;
        check("postrst_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("postrst_grants_left", 32'(exp_grant.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
